// File: rtl/melody_player.sv
// Looping square-wave melody player with an internal note RAM of half-periods.
// Optional MELODY_STACCATO_EN silences the final ARTIC_TICKS cycles of every note.
module melody_player #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned HALF_W      = 20,
  parameter int unsigned DUR_W       = 32,
  parameter int unsigned NOTE_TICKS  = 12_000_000,
  parameter int unsigned GAP_TICKS   = 0,
  parameter int unsigned ARTIC_TICKS = 1_000_000,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] last_idx_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [HALF_W-1:0] wr_half_i,
  output logic              tone_o,
  output logic              playing_o,
  output logic [ADDR_W-1:0] note_idx_o,
  output logic              song_done_o
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  localparam logic [DUR_W-1:0]  NoteLast = DUR_W'(NOTE_TICKS - 1);
  localparam logic [DUR_W-1:0]  GapLast  = DUR_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] IdxMax   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IdxZero  = '0;
`ifdef MELODY_STACCATO_EN
  localparam bit StaccatoEn = 1'b1;
`else
  localparam bit StaccatoEn = 1'b0;
`endif
  // Legato builds put the silent tail past the last count so it never triggers.
  localparam logic [DUR_W:0] ArticStart =
      (DUR_W + 1)'(StaccatoEn ? NOTE_TICKS - ARTIC_TICKS : NOTE_TICKS);

  logic [HALF_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx_next;
  logic [HALF_W-1:0] cur_half_q, cur_half_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [DUR_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              tone_q, tone_d;
  logic              done_q, done_d;

  // Loads read mem_q before this edge's write lands, so a colliding load sees the old value.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_half_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cur_half_q <= '0;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_half_q <= cur_half_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_half_d = cur_half_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    idx_next   = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;

    if (!enable_i) begin
      state_d    = StIdle;
      idx_d      = '0;
      half_cnt_d = '0;
      dur_cnt_d  = '0;
      gap_cnt_d  = '0;
      tone_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StPlay;
          idx_d      = '0;
          cur_half_d = mem_q[IdxZero];
          half_cnt_d = '0;
          dur_cnt_d  = '0;
          tone_d     = 1'b0;
        end
        StPlay: begin
          if (dur_cnt_q == NoteLast) begin
            dur_cnt_d  = '0;
            half_cnt_d = '0;
            tone_d     = 1'b0;
            if (idx_q != last_idx_i) begin
              idx_d      = idx_next;
              cur_half_d = mem_q[idx_next];
            end else begin
              done_d = 1'b1;
              if (GAP_TICKS == 0) begin
                idx_d      = '0;
                cur_half_d = mem_q[IdxZero];
              end else begin
                state_d   = StGap;
                gap_cnt_d = '0;
              end
            end
          end else begin
            dur_cnt_d = dur_cnt_q + 1'b1;
            if (cur_half_q == '0) begin
              half_cnt_d = '0;
              tone_d     = 1'b0;
            end else if (half_cnt_q == cur_half_q - 1'b1) begin
              half_cnt_d = '0;
              tone_d     = ~tone_q;
            end else begin
              half_cnt_d = half_cnt_q + 1'b1;
            end
          end
        end
        StGap: begin
          tone_d = 1'b0;
          if (gap_cnt_q == GapLast) begin
            state_d    = StPlay;
            idx_d      = '0;
            cur_half_d = mem_q[IdxZero];
            half_cnt_d = '0;
            dur_cnt_d  = '0;
            gap_cnt_d  = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign tone_o      = tone_q & ({1'b0, dur_cnt_q} < ArticStart);
  assign playing_o   = (state_q != StIdle);
  assign note_idx_o  = idx_q;
  assign song_done_o = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: two instances (no gap / 7-cycle gap) against a time-based model.
module tb_melody_player;
  localparam int unsigned Depth = 8;
  localparam int unsigned AddrW = 3;
  localparam int unsigned HalfW = 8;
  localparam int unsigned DurW  = 16;
  localparam int unsigned Note  = 20;
  localparam int unsigned Artic = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [AddrW-1:0] last_idx;
  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [HalfW-1:0] wr_half;
  logic [1:0]       tone_w, play_w, done_w;
  logic [AddrW-1:0] idx_a, idx_b;

  melody_player #(.DEPTH(Depth), .HALF_W(HalfW), .DUR_W(DurW), .NOTE_TICKS(Note),
                  .GAP_TICKS(0), .ARTIC_TICKS(Artic)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .last_idx_i(last_idx), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_half_i(wr_half), .tone_o(tone_w[0]), .playing_o(play_w[0]),
    .note_idx_o(idx_a), .song_done_o(done_w[0]));

  melody_player #(.DEPTH(Depth), .HALF_W(HalfW), .DUR_W(DurW), .NOTE_TICKS(Note),
                  .GAP_TICKS(7), .ARTIC_TICKS(Artic)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .last_idx_i(last_idx), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_half_i(wr_half), .tone_o(tone_w[1]), .playing_o(play_w[1]),
    .note_idx_o(idx_b), .song_done_o(done_w[1]));

  always #5 clk = ~clk;

  // Model: each instance is described by time since play start and the latched half-period.
  int unsigned      gap_len [2];
  bit               act     [2];
  int unsigned      pcnt    [2];
  int unsigned      mhalf   [2];
  logic [HalfW-1:0] mmem    [Depth];
  int               checks = 0;
  int               passes = 0;

  typedef struct packed {
    bit       en;
    bit       tone;
    bit       play;
    bit [2:0] idx;
    bit       done;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input int k, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s[dut%0d] at %0t: got %0d expected %0d", nm, k, $time, got, exp);
  endtask

  function automatic int idx_of(input int k);
    return (k == 0) ? int'(idx_a) : int'(idx_b);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int unsigned notes_len, pass_len, q, t, et, ep, ed;
      notes_len = (int'(last_idx) + 1) * Note;
      pass_len  = notes_len + gap_len[k];
      et = 0; ep = 0; ed = 0;
      if (act[k]) begin
        q  = pcnt[k] % pass_len;
        ep = 1;
        ed = (pcnt[k] >= notes_len && (pcnt[k] - notes_len) % pass_len == 0) ? 1 : 0;
        if (q < notes_len) begin
          t  = q % Note;
          et = (mhalf[k] == 0) ? 0 : (t / mhalf[k]) % 2;
`ifdef MELODY_STACCATO_EN
          if (t >= Note - Artic) et = 0;
`endif
          chk("note_idx", k, idx_of(k), int'(q / Note));
        end
      end else begin
        chk("note_idx", k, idx_of(k), 0);
      end
      chk("tone", k, int'(tone_w[k]), int'(et));
      chk("playing", k, int'(play_w[k]), int'(ep));
      chk("song_done", k, int'(done_w[k]), int'(ed));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int unsigned notes_len, q;
      notes_len = (int'(last_idx) + 1) * Note;
      if (!enable || rst) begin
        act[k] = 1'b0;
      end else if (!act[k]) begin
        act[k] = 1'b1; pcnt[k] = 0; mhalf[k] = int'(mmem[0]);
      end else begin
        pcnt[k]++;
        q = pcnt[k] % (notes_len + gap_len[k]);
        if (q < notes_len && q % Note == 0) mhalf[k] = int'(mmem[q / Note]);
      end
    end
    if (wr_en) mmem[wr_addr] = wr_half;
    #1;
    check_all();
  endtask

  task automatic write_note(input int a, input int h);
    wr_en = 1'b1; wr_addr = AddrW'(a); wr_half = HalfW'(h);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int exp_stac;
    gap_len[0] = 0; gap_len[1] = 7;
    for (int k = 0; k < 2; k++) begin act[k] = 0; pcnt[k] = 0; mhalf[k] = 0; end
    for (int i = 0; i < Depth; i++) mmem[i] = '0;
    rst = 1'b1; enable = 1'b0; last_idx = '0; wr_en = 1'b0; wr_addr = '0; wr_half = '0;
    #1;
    check_all();
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < Depth; i++) write_note(i, i % 4);

    // Tone: RAM[0]=3, one-note song; first cycles of the note, then enable drop.
    tbl[0] = '{1, 0, 1, 0, 0}; tbl[1] = '{1, 0, 1, 0, 0}; tbl[2] = '{1, 0, 1, 0, 0};
    tbl[3] = '{1, 1, 1, 0, 0}; tbl[4] = '{1, 1, 1, 0, 0}; tbl[5] = '{1, 1, 1, 0, 0};
    tbl[6] = '{1, 0, 1, 0, 0}; tbl[7] = '{1, 0, 1, 0, 0}; tbl[8] = '{0, 0, 0, 0, 0};
    write_note(0, 3);
    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].en;
      tick();
      chk("tbl_tone", 0, int'(tone_w[0]), int'(tbl[i].tone));
      chk("tbl_playing", 0, int'(play_w[0]), int'(tbl[i].play));
      chk("tbl_idx", 0, int'(idx_a), int'(tbl[i].idx));
      chk("tbl_done", 0, int'(done_w[0]), int'(tbl[i].done));
    end

    // Boundary at p=20: song_done pulses, tone low; gap instance then idles 7 cycles.
    enable = 1'b1;
    repeat (21) tick();
    chk("bound_done", 0, int'(done_w[0]), 1);
    chk("bound_tone", 0, int'(tone_w[0]), 0);
    chk("gap_done", 1, int'(done_w[1]), 1);
    repeat (6) tick();
    chk("gap_playing", 1, int'(play_w[1]), 1);
    chk("gap_tone", 1, int'(tone_w[1]), 0);
    enable = 1'b0;
    tick();

    // Sequence {2,0,5}: note_idx steps every 20 cycles.
    write_note(0, 2); write_note(1, 0); write_note(2, 5);
    last_idx = 3'd2; enable = 1'b1;
    for (int c = 0; c < 61; c++) begin
      tick();
      if (c % 20 == 0) chk("seq_idx", 0, int'(idx_a), (c / 20) % 3);
    end

    // Asynchronous reset mid-note; RAM contents must survive.
    #2 rst = 1'b1;
    #1;
    chk("rst_tone", 0, int'(tone_w[0]), 0);
    chk("rst_playing", 0, int'(play_w[0]), 0);
    chk("rst_idx", 0, int'(idx_a), 0);
    enable = 1'b0;
    tick();
    #2 rst = 1'b0;
    enable = 1'b1;
    repeat (30) tick();

    // Enable drop mid-note.
    enable = 1'b0;
    tick();
    chk("drop_playing", 0, int'(play_w[0]), 0);
    chk("drop_tone", 1, int'(tone_w[1]), 0);

    // Collision: RAM[0]=9 written on the edge that reloads RAM[0].
    last_idx = '0;
    write_note(0, 2);
    enable = 1'b1;
    repeat (20) tick();
    wr_en = 1'b1; wr_addr = '0; wr_half = 8'd9;
    tick();
    wr_en = 1'b0;
    repeat (2) tick();
    chk("coll_old", 0, int'(tone_w[0]), 1);
    repeat (27) tick();
    chk("coll_new", 0, int'(tone_w[0]), 1);
    enable = 1'b0;
    tick();

    // Staccato tail: half-period 1 would be high at t=17.
    write_note(0, 1);
    enable = 1'b1;
    repeat (18) tick();
`ifdef MELODY_STACCATO_EN
    exp_stac = 0;
`else
    exp_stac = 1;
`endif
    chk("artic_tone", 0, int'(tone_w[0]), exp_stac);
    enable = 1'b0;
    tick();

    // Randomised songs with writes during play.
    for (int r = 0; r < 12; r++) begin
      last_idx = AddrW'($urandom_range(0, Depth - 1));
      for (int i = 0; i < Depth; i++) write_note(i, $urandom_range(0, 5));
      enable = 1'b1;
      repeat ($urandom_range(30, 220)) begin
        wr_en   = ($urandom_range(0, 7) == 0);
        wr_addr = AddrW'($urandom_range(0, Depth - 1));
        wr_half = HalfW'($urandom_range(0, 6));
        tick();
      end
      wr_en = 1'b0; enable = 1'b0;
      repeat (2) tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
